// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the RX and TX halves.
package uart_pkg;
   localparam logic UART_IDLE_LVL = 1'b1;
   localparam int   PAR_W         = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } rx_state_e;

   // Narrower words are zero-extended by the caller; zeros do not change the XOR.
   function automatic logic parity_bit(input logic [PAR_W-1:0] data, input logic even);
      return even ? ^data : ~^data;
   endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle level.
module uart_rx_sync
   import uart_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= UART_IDLE_LVL;
         q    <= UART_IDLE_LVL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/optional parity/stop framing, sampled at mid-bit.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   input  logic                 parity_en,
   input  logic                 even_parity,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 rx_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 rx_busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

   logic                 rx_s;
   rx_state_e            state, state_nxt;
   logic [CW-1:0]        cnt;
   logic [BW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 perr_int, par_en_l, even_l;
   logic                 bit_end, mid;

   uart_rx_sync u_sync (.clk(clk), .rst(rst), .d(rx), .q(rx_s));

   assign bit_end = (cnt == CNT_LAST);
   assign mid     = (cnt == CNT_MID);
   assign rx_busy = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (rx_s != UART_IDLE_LVL) state_nxt = ST_START;
         ST_START:  if (mid) state_nxt = rx_s ? ST_IDLE : ST_DATA;
         ST_DATA:   if (bit_end && bit_idx == IDX_LAST)
                       state_nxt = par_en_l ? ST_PARITY : ST_STOP;
         ST_PARITY: if (bit_end) state_nxt = ST_STOP;
         ST_STOP:   if (bit_end) state_nxt = rx_s ? ST_IDLE : ST_BREAK;
         ST_BREAK:  if (rx_s) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         perr_int   <= 1'b0;
         par_en_l   <= 1'b0;
         even_l     <= 1'b0;
         data_out   <= '0;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (rx_s != UART_IDLE_LVL) begin
                  par_en_l <= parity_en;
                  even_l   <= even_parity;
                  perr_int <= 1'b0;
               end
            end
            ST_START: begin
               cnt     <= mid ? '0 : cnt + 1'b1;
               bit_idx <= '0;
            end
            ST_DATA: begin
               if (bit_end) begin
                  cnt   <= '0;
                  shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                  if (bit_idx != IDX_LAST) bit_idx <= bit_idx + 1'b1;
               end else cnt <= cnt + 1'b1;
            end
            ST_PARITY: begin
               if (bit_end) begin
                  cnt      <= '0;
                  perr_int <= (rx_s != parity_bit(PAR_W'(shreg), even_l));
               end else cnt <= cnt + 1'b1;
            end
            ST_STOP: begin
               if (bit_end) begin
                  cnt        <= '0;
                  data_out   <= shreg;
                  rx_valid   <= 1'b1;
                  parity_err <= par_en_l & perr_int;
                  frame_err  <= ~rx_s;
               end else cnt <= cnt + 1'b1;
            end
            default: cnt <= '0;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames vs. a frame-level model.
module tb_uart_rx;
   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx = 1'b1;
   logic       parity_en = 1'b0;
   logic       even_parity = 1'b0;
   logic [7:0] data_out;
   logic       rx_valid, parity_err, frame_err, rx_busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int t_start = 0;
   int lat_last = 0;
   int dbl_valid = 0;
   logic prev_valid = 1'b0;

   logic [9:0] got_q[$];
   logic [9:0] exp_q[$];

   uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
      .clk(clk), .rst(rst), .rx(rx), .parity_en(parity_en), .even_parity(even_parity),
      .data_out(data_out), .rx_valid(rx_valid), .parity_err(parity_err),
      .frame_err(frame_err), .rx_busy(rx_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rx_valid) begin
         got_q.push_back({data_out, parity_err, frame_err});
         lat_last = cyc - t_start;
         if (prev_valid) dbl_valid++;
      end
      prev_valid = rx_valid;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic bit_t(input logic b);
      rx = b;
      repeat (CPB) @(negedge clk);
   endtask

   // Line-level frame driver; also records what a correct receiver must report.
   task automatic send_frame(input logic [7:0] d, input logic pe, input logic ev,
                             input logic flip_par, input logic stop);
      logic good_par, sent_par;
      // even parity: total ones incl. parity bit is even; odd: total is odd
      good_par = ($countones(d) % 2 == 1) ? ev : ~ev;
      sent_par = flip_par ? ~good_par : good_par;
      parity_en   = pe;
      even_parity = ev;
      t_start = cyc;
      bit_t(1'b0);
      for (int i = 0; i < 8; i++) bit_t(d[i]);
      if (pe) bit_t(sent_par);
      exp_q.push_back({d, pe & flip_par, ~stop});
      bit_t(stop);
      rx = 1'b1;
   endtask

   task automatic check_frames(input string tag);
      logic [9:0] g, e;
      chk({tag, "_count"}, got_q.size(), exp_q.size());
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         chk({tag, "_data"}, g[9:2], e[9:2]);
         chk({tag, "_perr"}, g[1], e[1]);
         chk({tag, "_ferr"}, g[0], e[0]);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [7:0] d;
      logic pe, ev, fl;

      repeat (3) @(negedge clk);
      chk("rst_data", data_out, 0);
      chk("rst_valid", rx_valid, 0);
      chk("rst_perr", parity_err, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_busy", rx_busy, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // 1: plain frame, latency
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      chk("t1_latency_in_range", (lat_last >= 154 && lat_last <= 156), 1);
      check_frames("t1");
      chk("t1_busy_after", rx_busy, 0);

      // 2: parity good/bad, even then odd
      send_frame(8'h03, 1'b1, 1'b1, 1'b0, 1'b1);
      send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b1);
      send_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b1);
      send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      check_frames("t2");

      // 3: stop bit low, then break
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
      rx = 1'b0;
      repeat (40 * CPB) @(negedge clk);
      chk("t3_busy_in_break", rx_busy, 1);
      check_frames("t3");
      rx = 1'b1;
      repeat (6) @(negedge clk);
      chk("t3_busy_released", rx_busy, 0);
      chk("t3_no_extra_valid", got_q.size(), 0);

      // 4: short glitch
      rx = 1'b0;
      repeat (6) @(negedge clk);
      rx = 1'b1;
      chk("t4_busy_during", rx_busy, 1);
      repeat (8) @(negedge clk);
      chk("t4_busy_idle", rx_busy, 0);
      repeat (CPB * 12) @(negedge clk);
      chk("t4_no_valid", got_q.size(), 0);

      // 5: reset during data bit 4 of 0xFF
      parity_en = 1'b0;
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (4 * CPB + 8) @(negedge clk);
      chk("t5_busy_before", rx_busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5_data_zero", data_out, 0);
      chk("t5_valid_zero", rx_valid, 0);
      chk("t5_perr_zero", parity_err, 0);
      chk("t5_ferr_zero", frame_err, 0);
      chk("t5_busy_zero", rx_busy, 0);
      repeat (8 * CPB) @(negedge clk);
      chk("t5_partial_dropped", got_q.size(), 0);
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      check_frames("t5");

      // 6: back-to-back with parity
      send_frame(8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
      send_frame(8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
      send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      check_frames("t6");

      // randomized frames
      for (int n = 0; n < 24; n++) begin
         d  = 8'($urandom_range(0, 255));
         pe = 1'($urandom_range(0, 1));
         ev = 1'($urandom_range(0, 1));
         fl = ($urandom_range(0, 3) == 0);
         send_frame(d, pe, ev, fl, 1'b1);
         repeat ($urandom_range(0, 20)) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      check_frames("rand");

      chk("valid_never_double", dbl_valid, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
